// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings for mem_req_arbiter: read/write FSM states, access type codes and
// requester IDs. Imported by the interface, the top level and the write buffer.
package mem_req_arbiter_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned LineW = 128;

  // Read FSM, one-hot.
  typedef enum logic [2:0] {
    RIdle = 3'b001,
    RReq  = 3'b010,
    RResp = 3'b100
  } rd_state_e;

  typedef enum logic {
    WEmpty = 1'b0,
    WFull  = 1'b1
  } wr_state_e;

  localparam logic [2:0] TypeByte = 3'b000;
  localparam logic [2:0] TypeHalf = 3'b001;
  localparam logic [2:0] TypeWord = 3'b010;
  localparam logic [2:0] TypeLine = 3'b100;

  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Signal bundle between the I/D caches, the arbiter and the bus bridge.
// modport master: the arbiter (it masters the memory-side channels and serves both caches).
// modport slave : the environment (caches + bridge) that drives the arbiter.
interface mem_req_arbiter_if;
  import mem_req_arbiter_pkg::*;

  logic             i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
  logic [2:0]       i_rd_type;
  logic [AddrW-1:0] i_rd_addr;
  logic [DataW-1:0] i_ret_data;

  logic             d_rd_req, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [2:0]       d_rd_type;
  logic [AddrW-1:0] d_rd_addr;
  logic [DataW-1:0] d_ret_data;

  logic             d_wr_req, d_wr_rdy;
  logic [2:0]       d_wr_type;
  logic [AddrW-1:0] d_wr_addr;
  logic [3:0]       d_wr_wstrb;
  logic [LineW-1:0] d_wr_data;

  logic             m_rd_req, m_rd_rdy, m_ret_valid, m_ret_last;
  logic [2:0]       m_rd_type;
  logic [AddrW-1:0] m_rd_addr;
  logic [DataW-1:0] m_ret_data;

  logic             m_wr_req, m_wr_rdy;
  logic [2:0]       m_wr_type;
  logic [AddrW-1:0] m_wr_addr;
  logic [3:0]       m_wr_wstrb;
  logic [LineW-1:0] m_wr_data;

  modport master (
    input  i_rd_req, i_rd_type, i_rd_addr,
    output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    input  d_rd_req, d_rd_type, d_rd_addr,
    output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
    output d_wr_rdy,
    output m_rd_req, m_rd_type, m_rd_addr,
    input  m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
    output m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
    input  m_wr_rdy
  );

  modport slave (
    output i_rd_req, i_rd_type, i_rd_addr,
    input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    output d_rd_req, d_rd_type, d_rd_addr,
    input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
    input  d_wr_rdy,
    input  m_rd_req, m_rd_type, m_rd_addr,
    output m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
    input  m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
    output m_wr_rdy
  );

endinterface

// File: rtl/mem_req_arbiter_wr_post_buf.sv
// One-entry posted write buffer for D-cache write-backs plus the read-after-write hazard
// comparator.
// Ports: clk_i/rst_i (sync, active-high); wr_* capture side (wr_rdy_o = buffer empty);
// m_wr_* drain side to memory; i/d_rd_line_i are the read line addresses to compare;
// i/d_haz_o flag a read that hits the buffered, not-yet-accepted line.
module mem_req_arbiter_wr_post_buf
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned LineOffW = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_req_i,
  input  logic [2:0]                wr_type_i,
  input  logic [AddrW-1:0]          wr_addr_i,
  input  logic [3:0]                wr_wstrb_i,
  input  logic [LineW-1:0]          wr_data_i,
  output logic                      wr_rdy_o,
  output logic                      m_wr_req_o,
  output logic [2:0]                m_wr_type_o,
  output logic [AddrW-1:0]          m_wr_addr_o,
  output logic [3:0]                m_wr_wstrb_o,
  output logic [LineW-1:0]          m_wr_data_o,
  input  logic                      m_wr_rdy_i,
  input  logic [AddrW-LineOffW-1:0] i_rd_line_i,
  input  logic [AddrW-LineOffW-1:0] d_rd_line_i,
  output logic                      i_haz_o,
  output logic                      d_haz_o
);

  wr_state_e        state_q, state_d;
  logic [2:0]       type_q, type_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [LineW-1:0] data_q, data_d;

  // Capture only when empty and drain only when full, so both never happen in one cycle.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    data_d  = data_q;
    case (state_q)
      WEmpty: begin
        if (wr_req_i) begin
          type_d  = wr_type_i;
          addr_d  = wr_addr_i;
          wstrb_d = wr_wstrb_i;
          data_d  = wr_data_i;
          state_d = WFull;
        end
      end
      WFull: begin
        if (m_wr_rdy_i) state_d = WEmpty;
      end
      default: state_d = WEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= WEmpty;
    else       state_q <= state_d;
    type_q  <= type_d;
    addr_q  <= addr_d;
    wstrb_q <= wstrb_d;
    data_q  <= data_d;
  end

  assign wr_rdy_o     = (state_q == WEmpty) && !rst_i;
  assign m_wr_req_o   = (state_q == WFull) && !rst_i;
  assign m_wr_type_o  = type_q;
  assign m_wr_addr_o  = addr_q;
  assign m_wr_wstrb_o = wstrb_q;
  assign m_wr_data_o  = data_q;

  assign i_haz_o = (state_q == WFull) && (i_rd_line_i == addr_q[AddrW-1:LineOffW]);
  assign d_haz_o = (state_q == WFull) && (d_rd_line_i == addr_q[AddrW-1:LineOffW]);

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory read channel and one write channel between the I and D caches.
// Reads are serialised with round-robin arbitration (read FSM here); D write-backs are
// posted through a one-entry buffer (mem_req_arbiter_wr_post_buf), and reads hitting the
// buffered line are stalled until the write is accepted.
// Ports: clk, reset (sync, active-high); bus = all cache- and memory-side handshakes.
// Optional MEM_ARB_PERF_EN adds perf_i_grants, perf_d_grants, perf_haz_stall counters.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned LineBytes = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.master bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_haz_stall
`endif
);

  localparam int unsigned LineOffW = $clog2(LineBytes);

  rd_state_e        rd_state_q, rd_state_d;
  req_id_e          last_grant_q, last_grant_d;  // also the owner of the current burst
  logic [2:0]       rd_type_q, rd_type_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;
  logic             i_haz, d_haz, i_cand, d_cand, grant, in_resp;
  req_id_e          winner;

  mem_req_arbiter_wr_post_buf #(
    .LineOffW (LineOffW)
  ) u_wr_post_buf (
    .clk_i        (clk),
    .rst_i        (reset),
    .wr_req_i     (bus.d_wr_req),
    .wr_type_i    (bus.d_wr_type),
    .wr_addr_i    (bus.d_wr_addr),
    .wr_wstrb_i   (bus.d_wr_wstrb),
    .wr_data_i    (bus.d_wr_data),
    .wr_rdy_o     (bus.d_wr_rdy),
    .m_wr_req_o   (bus.m_wr_req),
    .m_wr_type_o  (bus.m_wr_type),
    .m_wr_addr_o  (bus.m_wr_addr),
    .m_wr_wstrb_o (bus.m_wr_wstrb),
    .m_wr_data_o  (bus.m_wr_data),
    .m_wr_rdy_i   (bus.m_wr_rdy),
    .i_rd_line_i  (bus.i_rd_addr[AddrW-1:LineOffW]),
    .d_rd_line_i  (bus.d_rd_addr[AddrW-1:LineOffW]),
    .i_haz_o      (i_haz),
    .d_haz_o      (d_haz)
  );

  always_comb begin
    i_cand       = bus.i_rd_req && !i_haz && !reset;
    d_cand       = bus.d_rd_req && !d_haz && !reset;
    grant        = 1'b0;
    winner       = last_grant_q;
    rd_state_d   = rd_state_q;
    last_grant_d = last_grant_q;
    rd_type_d    = rd_type_q;
    rd_addr_d    = rd_addr_q;
    unique case (rd_state_q)
      RIdle: begin
        // On a tie the requester that was not served last wins.
        if (i_cand && d_cand) winner = (last_grant_q == ReqI) ? ReqD : ReqI;
        else if (i_cand)      winner = ReqI;
        else if (d_cand)      winner = ReqD;
        grant = i_cand || d_cand;
        if (grant) begin
          last_grant_d = winner;
          rd_type_d    = (winner == ReqI) ? bus.i_rd_type : bus.d_rd_type;
          rd_addr_d    = (winner == ReqI) ? bus.i_rd_addr : bus.d_rd_addr;
          rd_state_d   = RReq;
        end
      end
      RReq: begin
        if (bus.m_rd_rdy) rd_state_d = RResp;
      end
      RResp: begin
        if (bus.m_ret_valid && bus.m_ret_last) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q   <= RIdle;
      last_grant_q <= ReqI;
    end else begin
      rd_state_q   <= rd_state_d;
      last_grant_q <= last_grant_d;
    end
    rd_type_q <= rd_type_d;
    rd_addr_q <= rd_addr_d;
  end

  assign bus.i_rd_rdy  = grant && (winner == ReqI);
  assign bus.d_rd_rdy  = grant && (winner == ReqD);
  assign bus.m_rd_req  = (rd_state_q == RReq) && !reset;
  assign bus.m_rd_type = rd_type_q;
  assign bus.m_rd_addr = rd_addr_q;

  // Beats arriving outside RResp (e.g. the tail of a burst cut short by reset) are dropped.
  assign in_resp         = (rd_state_q == RResp) && !reset;
  assign bus.i_ret_valid = in_resp && (last_grant_q == ReqI) && bus.m_ret_valid;
  assign bus.i_ret_last  = in_resp && (last_grant_q == ReqI) && bus.m_ret_last;
  assign bus.d_ret_valid = in_resp && (last_grant_q == ReqD) && bus.m_ret_valid;
  assign bus.d_ret_last  = in_resp && (last_grant_q == ReqD) && bus.m_ret_last;
  assign bus.i_ret_data  = bus.m_ret_data;
  assign bus.d_ret_data  = bus.m_ret_data;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_i_d, perf_d_q, perf_d_d, perf_haz_q, perf_haz_d;

  always_comb begin
    perf_i_d   = perf_i_q + 32'(bus.i_rd_rdy);
    perf_d_d   = perf_d_q + 32'(bus.d_rd_rdy);
    perf_haz_d = perf_haz_q + 32'((bus.i_rd_req && i_haz) || (bus.d_rd_req && d_haz));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_q   <= '0;
      perf_d_q   <= '0;
      perf_haz_q <= '0;
    end else begin
      perf_i_q   <= perf_i_d;
      perf_d_q   <= perf_d_d;
      perf_haz_q <= perf_haz_d;
    end
  end

  assign perf_i_grants  = perf_i_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_haz_stall = perf_haz_q;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic clk;
  logic reset;

  mem_req_arbiter_if bus();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i, perf_d, perf_haz;
`endif

  mem_req_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_grants  (perf_i),
    .perf_d_grants  (perf_d),
    .perf_haz_stall (perf_haz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] typ; logic [31:0] addr; } mrd_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;
  typedef struct packed {
    logic [2:0] typ; logic [31:0] addr; logic [3:0] wstrb; logic [127:0] data;
  } mwr_t;

  mrd_t  mrd_q[$];
  beat_t i_q[$];
  beat_t d_q[$];
  mwr_t  mwr_q[$];
  bit    grant_q[$];  // 0 = I, 1 = D

  int checks = 0;
  int errors = 0;
  int beat_no = -1;
  bit mem_busy = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ {8{4'(b + 1)}};
  endfunction

  // Pushes everything a completed read should produce, in grant order.
  task automatic expect_rd(input bit who, input logic [2:0] t, input logic [31:0] a);
    int nb;
    nb = (t == TypeLine) ? 4 : 1;
    grant_q.push_back(who);
    mrd_q.push_back('{typ: t, addr: a});
    for (int b = 0; b < nb; b++) begin
      if (who) d_q.push_back('{data: beat_data(a, b), last: (b == nb - 1)});
      else     i_q.push_back('{data: beat_data(a, b), last: (b == nb - 1)});
    end
  endtask

  // Memory read responder: one stall cycle before accepting, then 4 or 1 beats.
  initial begin
    logic [31:0] a;
    logic [2:0]  t;
    int          nb;
    bus.m_rd_rdy    = 1'b0;
    bus.m_ret_valid = 1'b0;
    bus.m_ret_last  = 1'b0;
    bus.m_ret_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_rd_req) begin
        mem_busy = 1'b1;
        a = bus.m_rd_addr;
        t = bus.m_rd_type;
        @(posedge clk); #1;
        bus.m_rd_rdy = 1'b1;
        @(posedge clk); #1;
        bus.m_rd_rdy = 1'b0;
        nb = (t == TypeLine) ? 4 : 1;
        for (int b = 0; b < nb; b++) begin
          beat_no         = b;
          bus.m_ret_valid = 1'b1;
          bus.m_ret_data  = beat_data(a, b);
          bus.m_ret_last  = (b == nb - 1);
          @(posedge clk); #1;
        end
        bus.m_ret_valid = 1'b0;
        bus.m_ret_last  = 1'b0;
        beat_no         = -1;
        mem_busy        = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.i_rd_rdy && bus.d_rd_rdy) unexpected("double_grant");
    if (bus.i_rd_rdy) begin
      if (grant_q.size() == 0) unexpected("grant_i");
      else chk("grant_order", 128'(1'b0), 128'(grant_q.pop_front()));
    end
    if (bus.d_rd_rdy) begin
      if (grant_q.size() == 0) unexpected("grant_d");
      else chk("grant_order", 128'(1'b1), 128'(grant_q.pop_front()));
    end
    if (bus.m_rd_req && bus.m_rd_rdy) begin
      if (mrd_q.size() == 0) unexpected("m_rd");
      else begin
        mrd_t e;
        e = mrd_q.pop_front();
        chk("m_rd_type", 128'(bus.m_rd_type), 128'(e.typ));
        chk("m_rd_addr", 128'(bus.m_rd_addr), 128'(e.addr));
      end
    end
    if (bus.i_ret_valid) begin
      if (i_q.size() == 0) unexpected("i_ret");
      else begin
        beat_t e;
        e = i_q.pop_front();
        chk("i_ret_data", 128'(bus.i_ret_data), 128'(e.data));
        chk("i_ret_last", 128'(bus.i_ret_last), 128'(e.last));
      end
    end
    if (bus.d_ret_valid) begin
      if (d_q.size() == 0) unexpected("d_ret");
      else begin
        beat_t e;
        e = d_q.pop_front();
        chk("d_ret_data", 128'(bus.d_ret_data), 128'(e.data));
        chk("d_ret_last", 128'(bus.d_ret_last), 128'(e.last));
      end
    end
    if (bus.m_wr_req && bus.m_wr_rdy) begin
      if (mwr_q.size() == 0) unexpected("m_wr");
      else begin
        mwr_t e;
        e = mwr_q.pop_front();
        chk("m_wr_type", 128'(bus.m_wr_type), 128'(e.typ));
        chk("m_wr_addr", 128'(bus.m_wr_addr), 128'(e.addr));
        chk("m_wr_wstrb", 128'(bus.m_wr_wstrb), 128'(e.wstrb));
        chk("m_wr_data", bus.m_wr_data, e.data);
      end
    end
  end

  // Called at posedge+1; returns the number of cycles until rd_rdy (1 = same cycle).
  task automatic rd(input bit who, input logic [2:0] t, input logic [31:0] a, output int lat);
    bit seen;
    lat = 0;
    if (who) begin
      bus.d_rd_req = 1'b1; bus.d_rd_type = t; bus.d_rd_addr = a;
    end else begin
      bus.i_rd_req = 1'b1; bus.i_rd_type = t; bus.i_rd_addr = a;
    end
    do begin
      @(negedge clk);
      lat++;
      seen = who ? bus.d_rd_rdy : bus.i_rd_rdy;
    end while (!seen && lat < 100);
    if (!seen) unexpected("rd_grant_timeout");
    @(posedge clk); #1;
    if (who) bus.d_rd_req = 1'b0;
    else     bus.i_rd_req = 1'b0;
  endtask

  task automatic wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                    input logic [127:0] dat);
    int n;
    n = 0;
    bus.d_wr_req = 1'b1; bus.d_wr_type = t; bus.d_wr_addr = a;
    bus.d_wr_wstrb = s; bus.d_wr_data = dat;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.d_wr_rdy && n < 100);
    if (!bus.d_wr_rdy) unexpected("wr_capture_timeout");
    @(posedge clk); #1;
    bus.d_wr_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mem_busy || i_q.size() != 0 || d_q.size() != 0 || mrd_q.size() != 0 ||
            grant_q.size() != 0 || mwr_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) unexpected("idle_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat_i, lat_d, n;
    bus.i_rd_req = 1'b1; bus.i_rd_type = TypeLine; bus.i_rd_addr = 32'h0;
    bus.d_rd_req = 1'b0; bus.d_rd_type = TypeWord; bus.d_rd_addr = 32'h0;
    bus.d_wr_req = 1'b0; bus.d_wr_type = TypeLine; bus.d_wr_addr = 32'h0;
    bus.d_wr_wstrb = 4'h0; bus.d_wr_data = '0;
    bus.m_wr_rdy = 1'b0;
    reset = 1'b1;

    // Reset state, with an I request pending that must not be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_rd_rdy", 128'(bus.i_rd_rdy), 128'(0));
    chk("rst_d_wr_rdy", 128'(bus.d_wr_rdy), 128'(0));
    chk("rst_m_rd_req", 128'(bus.m_rd_req), 128'(0));
    chk("rst_m_wr_req", 128'(bus.m_wr_req), 128'(0));
    chk("rst_i_ret_valid", 128'(bus.i_ret_valid), 128'(0));
    @(posedge clk); #1;
    bus.i_rd_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_d_wr_rdy", 128'(bus.d_wr_rdy), 128'(1));
    chk("idle_m_rd_req", 128'(bus.m_rd_req), 128'(0));
    @(posedge clk); #1;

    // I-only line read.
    expect_rd(1'b0, TypeLine, 32'h1C00_0040);
    rd(1'b0, TypeLine, 32'h1C00_0040, lat_i);
    chk_int("i_grant_lat", lat_i, 1);
    wait_idle();

    // Simultaneous I and D after an I grant: D, I, then again D, I.
    expect_rd(1'b1, TypeLine, 32'h0000_4000);
    expect_rd(1'b0, TypeLine, 32'h0000_1000);
    fork
      rd(1'b0, TypeLine, 32'h0000_1000, lat_i);
      rd(1'b1, TypeLine, 32'h0000_4000, lat_d);
    join
    chk_int("rr1_d_lat", lat_d, 1);
    chk_int("rr1_i_lat", lat_i, 8);
    wait_idle();
    expect_rd(1'b1, TypeWord, 32'h0000_4444);
    expect_rd(1'b0, TypeWord, 32'h0000_1110);
    fork
      rd(1'b0, TypeWord, 32'h0000_1110, lat_i);
      rd(1'b1, TypeWord, 32'h0000_4444, lat_d);
    join
    chk_int("rr2_d_lat", lat_d, 1);
    chk_int("rr2_i_lat", lat_i, 5);
    wait_idle();

    // Hazard: buffered line write at 0x1230 stalls the D read of 0x1234, not the I read.
    mwr_q.push_back('{typ: TypeLine, addr: 32'h0000_1230, wstrb: 4'hF,
                      data: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210});
    wr(TypeLine, 32'h0000_1230, 4'hF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    expect_rd(1'b0, TypeLine, 32'h0000_2000);
    expect_rd(1'b1, TypeWord, 32'h0000_1234);
    fork
      rd(1'b0, TypeLine, 32'h0000_2000, lat_i);
      rd(1'b1, TypeWord, 32'h0000_1234, lat_d);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("haz_d_rd_rdy", 128'(bus.d_rd_rdy), 128'(0));
        end
        @(posedge clk); #1;
        bus.m_wr_rdy = 1'b1;
        @(posedge clk); #1;
        bus.m_wr_rdy = 1'b0;
      end
    join
    chk_int("haz_i_lat", lat_i, 1);
    chk_int("haz_d_lat", lat_d, 12);
    wait_idle();

    // Uncached word write: d_wr_rdy stays low until memory accepts.
    mwr_q.push_back('{typ: TypeWord, addr: 32'hBFAF_8000, wstrb: 4'b0011,
                      data: {96'h0, 32'hDEAD_BEEF}});
    wr(TypeWord, 32'hBFAF_8000, 4'b0011, {96'h0, 32'hDEAD_BEEF});
    repeat (3) begin
      @(negedge clk);
      chk("wr_full_d_wr_rdy", 128'(bus.d_wr_rdy), 128'(0));
      chk("wr_full_m_wr_req", 128'(bus.m_wr_req), 128'(1));
    end
    @(posedge clk); #1;
    bus.m_wr_rdy = 1'b1;
    @(posedge clk); #1;
    bus.m_wr_rdy = 1'b0;
    @(negedge clk);
    chk("wr_posted_d_wr_rdy", 128'(bus.d_wr_rdy), 128'(1));
    chk("wr_posted_m_wr_req", 128'(bus.m_wr_req), 128'(0));
    wait_idle();

    // Reset after the 2nd of 4 beats: only two beats reach I.
    grant_q.push_back(1'b0);
    mrd_q.push_back('{typ: TypeLine, addr: 32'h0000_3000});
    i_q.push_back('{data: beat_data(32'h0000_3000, 0), last: 1'b0});
    i_q.push_back('{data: beat_data(32'h0000_3000, 1), last: 1'b0});
    rd(1'b0, TypeLine, 32'h0000_3000, lat_i);
    n = 0;
    while (beat_no != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (beat_no != 1) unexpected("beat_wait_timeout");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_burst_i_ret_valid", 128'(bus.i_ret_valid), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_m_rd_req", 128'(bus.m_rd_req), 128'(0));
    chk("post_rst_i_ret_valid", 128'(bus.i_ret_valid), 128'(0));
    chk("post_rst_d_ret_valid", 128'(bus.d_ret_valid), 128'(0));
    wait_idle();
    expect_rd(1'b0, TypeWord, 32'h0000_0040);
    rd(1'b0, TypeWord, 32'h0000_0040, lat_i);
    chk_int("post_rst_i_lat", lat_i, 1);
    wait_idle();

    chk_int("queues_drained",
            i_q.size() + d_q.size() + mrd_q.size() + mwr_q.size() + grant_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
